// File: rtl/aes_core_arbiter.sv
// ---------------------------------------------------------------------------
// aes_core_arbiter
//   Shares one AES core among P_NUM_REQ requesters with round-robin
//   arbitration. The winner receives a registered one-hot grant. The core
//   receives a one-cycle start pulse. The job ends on the core's done pulse
//   (ack to the owner) or on watchdog expiry (err to the owner).
//
// Ports
//   iClk      in   clock, rising edge
//   iRst      in   asynchronous active-high reset
//   iReq      in   [P_NUM_REQ] request levels, held until ack/err
//   oGnt      out  [P_NUM_REQ] one-hot grant, high from GRANT through WAIT
//   oGntIdx   out  [P_IDX_W]   binary index of the current/last grant
//   oAck      out  [P_NUM_REQ] one-cycle completion pulse to the owner
//   oErr      out  [P_NUM_REQ] one-cycle timeout pulse to the owner
//   oStAes    out  one-cycle start pulse to the AES core
//   iAesDone  in   one-cycle done pulse from the AES core
//   oBusy     out  high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module aes_core_arbiter #(
  parameter int P_NUM_REQ = 4,
  parameter int P_IDX_W   = 2,
  parameter int P_TIMEOUT = 32,
  parameter int P_TO_W    = 6
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [P_NUM_REQ-1:0] iReq,
  output logic [P_NUM_REQ-1:0] oGnt,
  output logic [P_IDX_W-1:0]   oGntIdx,
  output logic [P_NUM_REQ-1:0] oAck,
  output logic [P_NUM_REQ-1:0] oErr,
  output logic                 oStAes,
  input  logic                 iAesDone,
  output logic                 oBusy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [P_TO_W-1:0]    L_WD_LAST = P_TO_W'(P_TIMEOUT - 1);
  localparam logic [P_IDX_W-1:0]   L_PTR_RST = P_IDX_W'(P_NUM_REQ - 1);
  localparam logic [P_NUM_REQ-1:0] L_ONE     = {{(P_NUM_REQ-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [P_NUM_REQ-1:0] gnt_q, gnt_d;
  logic [P_NUM_REQ-1:0] ack_q, ack_d;
  logic [P_NUM_REQ-1:0] err_q, err_d;
  logic [P_IDX_W-1:0]   idx_q, idx_d;
  logic [P_IDX_W-1:0]   ptr_q, ptr_d;
  logic [P_TO_W-1:0]    wd_q, wd_d;
  logic                 st_q, st_d;
  logic                 busy_q, busy_d;

  logic [P_IDX_W-1:0]   win_idx_s;
  logic [P_IDX_W-1:0]   cand_idx_s;
  logic                 win_vld_s;

  // Round-robin winner: first requester found from ptr+1 upward with wrap.
  // The loop runs from the farthest candidate down to the nearest so the
  // last hit written is the nearest one after the pointer.
  always_comb begin
    win_idx_s  = '0;
    win_vld_s  = 1'b0;
    cand_idx_s = '0;
    for (int i = P_NUM_REQ; i >= 1; i--) begin
      cand_idx_s = P_IDX_W'((int'(ptr_q) + i) % P_NUM_REQ);
      if (iReq[cand_idx_s]) begin
        win_idx_s = cand_idx_s;
        win_vld_s = 1'b1;
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    ack_d   = '0;
    err_d   = '0;
    st_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_d = ST_GRANT;
          gnt_d   = L_ONE << win_idx_s;
          idx_d   = win_idx_s;
          st_d    = 1'b1;
        end else begin
          gnt_d   = '0;
        end
      end
      ST_GRANT: begin
        // A done pulse here cannot belong to this job and is ignored.
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d = wd_q + P_TO_W'(1);
        // Done is checked first so it wins over a same-cycle timeout.
        if (iAesDone) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          ack_d   = gnt_q;
        end else if (wd_q == L_WD_LAST) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          err_d   = gnt_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RELEASE: begin
        // The just-served requester becomes lowest priority.
        ptr_d   = idx_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= L_PTR_RST;
      wd_q    <= '0;
      st_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      st_q    <= st_d;
      busy_q  <= busy_d;
    end
  end

  assign oGnt    = gnt_q;
  assign oGntIdx = idx_q;
  assign oAck    = ack_q;
  assign oErr    = err_q;
  assign oStAes  = st_q;
  assign oBusy   = busy_q;

endmodule
